// File: rtl/pdua.sv
`default_nettype none
// ============================================================================
//  Module      : pdua
//  Description : Accumulator datapath for a small teaching processor.
//                It holds the register bank, the ALU with a post-shifter,
//                the flag register, MAR/MDR/IR and the internal memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdua #(
    parameter int MAX_WIDTH  = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_rdn,
    input  logic                  enaf,
    input  logic [2:0]            selop,
    input  logic [1:0]            shamt,
    output logic                  C,
    output logic                  N,
    output logic                  P,
    output logic                  Z,
    input  logic                  bank_wr_en,
    input  logic [ADDR_WIDTH-1:0] BusB_addr,
    input  logic [ADDR_WIDTH-1:0] BusC_addr,
    input  logic                  sclr,
    input  logic                  ir_en,
    input  logic                  mar_en,
    input  logic                  mdr_en,
    input  logic                  mdr_alu_n,
    output logic [4:0]            out_IR
);

    localparam int                 c_NREG = 2 ** ADDR_WIDTH;
    localparam int                 c_MEMW = 2 ** MAX_WIDTH;
    localparam int                 c_ACC  = 7;
    localparam logic [MAX_WIDTH:0] c_ONE  = (MAX_WIDTH + 1)'(1);

    logic [MAX_WIDTH-1:0] r_bank [c_NREG];
    logic [MAX_WIDTH-1:0] r_mem  [c_MEMW];
    logic [MAX_WIDTH-1:0] r_mar;
    logic [MAX_WIDTH-1:0] r_mdr;
    logic [4:0]           r_ir;
    logic                 r_c;
    logic                 r_n;
    logic                 r_p;
    logic                 r_z;

    logic [MAX_WIDTH-1:0] w_busa;
    logic [MAX_WIDTH-1:0] w_busb;
    logic [MAX_WIDTH-1:0] w_busc;
    logic [MAX_WIDTH-1:0] w_y;
    logic [MAX_WIDTH-1:0] w_mem_rd;
    logic [MAX_WIDTH:0]   w_ext;
    logic                 w_carry;

    assign w_busa   = r_bank[c_ACC];
    assign w_busb   = mdr_alu_n ? r_mdr : r_bank[BusB_addr];
    assign w_mem_rd = r_mem[r_mar];

    // Every op is computed one bit wider; logic ops leave the top bit 0,
    // so the carry is simply the extension bit.
    always_comb begin
        w_ext = '0;
        case (selop)
            3'b000:  w_ext = {1'b0, w_busb};
            3'b001:  w_ext = {1'b0, w_busa & w_busb};
            3'b010:  w_ext = {1'b0, w_busa | w_busb};
            3'b011:  w_ext = {1'b0, w_busa ^ w_busb};
            3'b100:  w_ext = {1'b0, ~w_busb};
            3'b101:  w_ext = {1'b0, w_busa} + {1'b0, w_busb};
            3'b110:  w_ext = {1'b0, w_busb} + c_ONE;
            default: w_ext = {1'b0, w_busa} + {1'b0, ~w_busb} + c_ONE;
        endcase
    end

    assign w_y     = w_ext[MAX_WIDTH-1:0];
    assign w_carry = w_ext[MAX_WIDTH];

    always_comb begin
        w_busc = w_y;
        case (shamt)
            2'b01:   w_busc = {w_y[MAX_WIDTH-2:0], 1'b0};
            2'b10:   w_busc = {1'b0, w_y[MAX_WIDTH-1:1]};
            2'b11:   w_busc = {w_y[0], w_y[MAX_WIDTH-1:1]};
            default: w_busc = w_y;
        endcase
    end

    // Bank reset leaves PC=1 so execution starts past address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_bank[i] <= (i == 0) ? MAX_WIDTH'(1) : MAX_WIDTH'(i);
            end
        end else if (bank_wr_en && !sclr) begin
            r_bank[BusC_addr] <= w_busc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !sclr && wr_rdn) begin
            r_mem[r_mar] <= r_mdr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || sclr) begin
            r_mar <= '0;
            r_mdr <= '0;
            r_ir  <= '0;
            r_c   <= 1'b0;
            r_n   <= 1'b0;
            r_p   <= 1'b0;
            r_z   <= 1'b0;
        end else begin
            if (mar_en) r_mar <= w_busc;
            if (mdr_en) r_mdr <= wr_rdn ? w_busc : w_mem_rd;
            if (ir_en)  r_ir  <= w_mem_rd[MAX_WIDTH-1 -: 5];
            if (enaf) begin
                r_c <= w_carry;
                r_n <= w_busc[MAX_WIDTH-1];
                r_p <= ~^w_busc;
                r_z <= (w_busc == '0);
            end
        end
    end

    assign C      = r_c;
    assign N      = r_n;
    assign P      = r_p;
    assign Z      = r_z;
    assign out_IR = r_ir;

endmodule
`default_nettype wire

// File: tb/tb_pdua.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pdua
//  Description : Directed and randomized checks of pdua against a
//                behavioural model of the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pdua;

    localparam int W = 8;
    localparam int M = 255;

    logic       clk = 1'b0;
    logic       rst, wr_rdn, enaf, bank_wr_en, sclr, ir_en, mar_en, mdr_en, mdr_alu_n;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic [2:0] BusB_addr, BusC_addr;
    logic       C, N, P, Z;
    logic [4:0] out_IR;

    always #5 clk = ~clk;

    pdua #(.MAX_WIDTH(W), .ADDR_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .wr_rdn(wr_rdn), .enaf(enaf), .selop(selop),
        .shamt(shamt), .C(C), .N(N), .P(P), .Z(Z), .bank_wr_en(bank_wr_en),
        .BusB_addr(BusB_addr), .BusC_addr(BusC_addr), .sclr(sclr),
        .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en),
        .mdr_alu_n(mdr_alu_n), .out_IR(out_IR)
    );

    int m_bank [8];
    int m_mem  [256];
    int m_mar, m_mdr, m_ir, m_c, m_n, m_p, m_z;
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; wr_rdn = 0; enaf = 0; bank_wr_en = 0; sclr = 0; ir_en = 0;
        mar_en = 0; mdr_en = 0; mdr_alu_n = 0; selop = 0; shamt = 0;
        BusB_addr = 0; BusC_addr = 0;
    endtask

    function automatic logic [15:0] flags_exp();
        return 16'(m_c * 8 + m_n * 4 + m_p * 2 + m_z);
    endfunction

    // One clock edge: predict from the rules, advance, compare visible state.
    task automatic step();
        int a, b, y, s, cy, busc, rd, k;
        a  = m_bank[7];
        b  = mdr_alu_n ? m_mdr : m_bank[BusB_addr];
        cy = 0;
        s  = 0;
        case (selop)
            3'd0: y = b;
            3'd1: y = a & b;
            3'd2: y = a | b;
            3'd3: y = a ^ b;
            3'd4: y = M - b;
            3'd5: s = a + b;
            3'd6: s = b + 1;
            default: s = a + (M - b) + 1;
        endcase
        if (selop >= 3'd5) begin
            y  = s % 256;
            cy = s / 256;
        end
        case (shamt)
            2'd0: busc = y;
            2'd1: busc = (y * 2) % 256;
            2'd2: busc = y / 2;
            default: busc = (y / 2) + (y % 2) * 128;
        endcase
        rd = m_mem[m_mar];
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_bank[i] = (i == 0) ? 1 : i;
            m_mar = 0; m_mdr = 0; m_ir = 0; m_c = 0; m_n = 0; m_p = 0; m_z = 0;
        end else if (sclr) begin
            m_mar = 0; m_mdr = 0; m_ir = 0; m_c = 0; m_n = 0; m_p = 0; m_z = 0;
        end else begin
            if (wr_rdn) m_mem[m_mar] = m_mdr;
            if (bank_wr_en) m_bank[BusC_addr] = busc;
            if (enaf) begin
                m_c = cy;
                m_n = busc / 128;
                m_p = ($countones(busc) % 2 == 0) ? 1 : 0;
                m_z = (busc == 0) ? 1 : 0;
            end
            if (mdr_en) m_mdr = wr_rdn ? busc : rd;
            if (ir_en) m_ir = rd / 8;
            if (mar_en) m_mar = busc;
        end
        k = $urandom_range(0, 7);
        check("flags", 16'({C, N, P, Z}), flags_exp());
        check("out_IR", 16'(out_IR), 16'(m_ir));
        check("acc", 16'(dut.r_bank[7]), 16'(m_bank[7]));
        check("pc", 16'(dut.r_bank[0]), 16'(m_bank[0]));
        check("mar", 16'(dut.r_mar), 16'(m_mar));
        check("mdr", 16'(dut.r_mdr), 16'(m_mdr));
        check("bank_k", 16'(dut.r_bank[k]), 16'(m_bank[k]));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 0;
        idle();

        // reset
        rst = 1; step();
        check("rst_r0", 16'(dut.r_bank[0]), 16'h1);
        check("rst_r3", 16'(dut.r_bank[3]), 16'h3);
        check("rst_r7", 16'(dut.r_bank[7]), 16'h7);
        check("rst_flags", 16'({C, N, P, Z}), 16'h0);
        check("rst_ir", 16'(out_IR), 16'h0);

        // ACC = 7 + R3
        idle(); selop = 3'b101; BusB_addr = 3; bank_wr_en = 1; BusC_addr = 7; enaf = 1; step();
        check("add_acc", 16'(dut.r_bank[7]), 16'h0A);
        check("add_flags", 16'({C, N, P, Z}), 16'b0010);

        // PC increments twice, flags hold
        idle(); selop = 3'b110; bank_wr_en = 1; step(); step();
        check("pc_inc", 16'(dut.r_bank[0]), 16'h3);
        check("pc_flags_hold", 16'({C, N, P, Z}), 16'b0010);

        // memory round trip through MAR/MDR
        idle(); BusB_addr = 5; mar_en = 1; step();
        check("mar_load", 16'(dut.r_mar), 16'h5);
        idle(); BusB_addr = 3; mdr_en = 1; wr_rdn = 1; step();
        check("mdr_busc", 16'(dut.r_mdr), 16'h3);
        idle(); wr_rdn = 1; step();
        check("mem_wr", 16'(dut.r_mem[5]), 16'h3);
        idle(); mdr_en = 1; step();
        check("mdr_mem", 16'(dut.r_mdr), 16'h3);
        idle(); mdr_alu_n = 1; bank_wr_en = 1; BusC_addr = 7; step();
        check("acc_mdr", 16'(dut.r_bank[7]), 16'h3);

        // fill memory with mem[i]=i, leaving MAR at 0xA8
        idle(); sclr = 1; step();
        for (int i = 0; i < 256 + 8'hA8; i++) begin
            idle(); selop = 3'b110; mdr_alu_n = 1; mar_en = 1; mdr_en = 1; wr_rdn = 1; step();
        end
        check("fill_mar", 16'(dut.r_mar), 16'hA8);
        idle(); ir_en = 1; step();
        check("ir_opcode", 16'(out_IR), 16'b10101);
        idle(); sclr = 1; step();
        check("sclr_ir", 16'(out_IR), 16'h0);
        check("sclr_flags", 16'({C, N, P, Z}), 16'h0);
        check("sclr_bank", 16'(dut.r_bank[0]), 16'h3);

        // overflow to zero, then shifted add
        idle(); mdr_alu_n = 1; selop = 3'b100; bank_wr_en = 1; BusC_addr = 7; step();
        check("acc_ff", 16'(dut.r_bank[7]), 16'hFF);
        idle(); selop = 3'b101; BusB_addr = 1; bank_wr_en = 1; BusC_addr = 7; enaf = 1; step();
        check("ovf_acc", 16'(dut.r_bank[7]), 16'h00);
        check("ovf_flags", 16'({C, N, P, Z}), 16'b1011);
        idle(); BusB_addr = 1; shamt = 2'b11; bank_wr_en = 1; BusC_addr = 7; step();
        check("ror_acc", 16'(dut.r_bank[7]), 16'h80);
        idle(); selop = 3'b101; BusB_addr = 1; shamt = 2'b01; bank_wr_en = 1; BusC_addr = 7; enaf = 1; step();
        check("shl_acc", 16'(dut.r_bank[7]), 16'h02);
        check("shl_flags", 16'({C, N, P, Z}), 16'b0000);

        // random control words
        for (int i = 0; i < 400; i++) begin
            idle();
            rst        = ($urandom_range(0, 39) == 0);
            sclr       = ($urandom_range(0, 19) == 0);
            wr_rdn     = 1'($urandom);
            enaf       = 1'($urandom);
            bank_wr_en = 1'($urandom);
            ir_en      = 1'($urandom);
            mar_en     = 1'($urandom);
            mdr_en     = 1'($urandom);
            mdr_alu_n  = 1'($urandom);
            selop      = 3'($urandom);
            shamt      = 2'($urandom);
            BusB_addr  = 3'($urandom);
            BusC_addr  = 3'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
